// File: rtl/light_pwm_if.sv
// -----------------------------------------------------------------------------
// light_pwm_if -- control/drive bundle for light_pwm.
//
// Signals
//   inSel       [1:0]            light selection code (picks a C_MASKS entry)
//   inBright    [C_PWM_BITS-1:0] brightness, 0 = off, all-ones = 100 %
//   inBlink                      blink enable
//   inTest                       lamp-test request (acted on at its rising edge)
//   outLED      [3*C_LEDS-1:0]   registered RGB drive, LED k at [3k+2:3k]
//   outTestBusy                  high while the lamp test runs
//
// Modports
//   master -- the controller side, drives the inputs and observes the LEDs
//   slave  -- the light_pwm side
// -----------------------------------------------------------------------------
interface light_pwm_if #(
  parameter int C_LEDS     = 4,
  parameter int C_PWM_BITS = 8
);
  logic [1:0]            inSel;
  logic [C_PWM_BITS-1:0] inBright;
  logic                  inBlink;
  logic                  inTest;
  logic [3*C_LEDS-1:0]   outLED;
  logic                  outTestBusy;

  modport master (
    output inSel, inBright, inBlink, inTest,
    input  outLED, outTestBusy
  );

  modport slave (
    input  inSel, inBright, inBlink, inTest,
    output outLED, outTestBusy
  );
endinterface

// File: rtl/light_pwm.sv
// -----------------------------------------------------------------------------
// light_pwm -- RGB indicator driver with PWM dimming, blinking and lamp test.
//
// Ports
//   clk   master clock
//   rstb  asynchronous active-low reset
//   bus   light_pwm_if.slave: inSel, inBright, inBlink, inTest in;
//         outLED, outTestBusy out (both registered)
//
// Behaviour
//   A free-running PWM counter runs over 0..2^C_PWM_BITS-2. inBright is
//   captured only when the counter wraps, so a period is never disturbed.
//   Each LED shows its C_COLORS triplet when enabled by the mask selected by
//   the registered inSel, gated by PWM and (when blinking) by the blink phase.
//   The blink phase toggles every T = C_CLK_FRQ/1000*C_BLINK_MS cycles.
//
// Optional lamp test (macro LIGHT_PWM_LAMPTEST_EN)
//   A rising edge of inTest lights LED C_LEDS-1 down to LED 0 in white at full
//   brightness for T cycles each, then normal operation resumes. Without the
//   macro, inTest is ignored and outTestBusy is constant 0.
// -----------------------------------------------------------------------------
module light_pwm #(
  parameter int                  C_LEDS     = 4,
  parameter int                  C_PWM_BITS = 8,
  parameter int                  C_CLK_FRQ  = 100000000,
  parameter int                  C_BLINK_MS = 500,
  parameter logic [3*C_LEDS-1:0] C_COLORS   = {3'b100, 3'b010, 3'b110, 3'b111},
  parameter logic [4*C_LEDS-1:0] C_MASKS    = {4'b1000, 4'b0100, 4'b0010, 4'b1001}
) (
  input  logic        clk,
  input  logic        rstb,
  light_pwm_if.slave  bus
);

  localparam int LED_W   = 3 * C_LEDS;
  // Blink half-period / lamp-test step length in clock cycles (must be >= 2).
  localparam int T       = C_CLK_FRQ / 1000 * C_BLINK_MS;
  localparam int PRESC_W = $clog2(T);
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(T - 1);
  // Counter stops one short of all-ones so that all-ones brightness is 100 %.
  localparam logic [C_PWM_BITS-1:0] CNT_LAST   = {{(C_PWM_BITS-1){1'b1}}, 1'b0};

  logic [1:0]            sel_q, sel_d;
  logic [C_PWM_BITS-1:0] bright_q, bright_d;
  logic [C_PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  phase_q, phase_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic                  busy_q, busy_d;

  logic [C_LEDS-1:0]     mask_sel;
  logic                  show;
  logic [LED_W-1:0]      normal_led;

  // ---------------------------------------------------------------------------
  // PWM, brightness capture, selection register and blink prescaler
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d    = bus.inSel;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bright_d = (cnt_q == CNT_LAST) ? bus.inBright : bright_q;

    presc_d  = presc_q;
    phase_d  = phase_q;
    if (!bus.inBlink) begin
      // Held in the on phase so a new blink starts with a full on half-period.
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Mask table is stored with code 0 in the top slot.
  always_comb begin
    mask_sel = C_MASKS[(3 - int'(sel_q)) * C_LEDS +: C_LEDS];
  end

  assign show = (cnt_q < bright_q) & (phase_q | ~bus.inBlink);

  generate
    for (genvar gi = 0; gi < C_LEDS; gi++) begin : g_normal
      assign normal_led[3*gi +: 3] = (mask_sel[gi] & show) ? C_COLORS[3*gi +: 3] : 3'b000;
    end
  endgenerate

`ifdef LIGHT_PWM_LAMPTEST_EN
  // ---------------------------------------------------------------------------
  // Lamp-test sequencer
  // ---------------------------------------------------------------------------
  localparam int STEP_W = (C_LEDS > 1) ? $clog2(C_LEDS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(C_LEDS - 1);

  typedef enum logic {
    ST_NORMAL,
    ST_TEST
  } state_t;

  state_t             state_q, state_d;
  logic               test_prev_q, test_prev_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PRESC_W-1:0] step_tmr_q, step_tmr_d;
  logic [LED_W-1:0]   test_led;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    step_tmr_d  = step_tmr_q;
    test_prev_d = bus.inTest;
    case (state_q)
      ST_NORMAL: begin
        if (bus.inTest && !test_prev_q) begin
          state_d    = ST_TEST;
          step_d     = '0;
          step_tmr_d = '0;
        end
      end
      ST_TEST: begin
        // Edges of inTest are deliberately not looked at here.
        if (step_tmr_q == PRESC_LAST) begin
          step_tmr_d = '0;
          if (step_q == STEP_LAST) begin
            state_d = ST_NORMAL;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          step_tmr_d = step_tmr_q + 1'b1;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Step 0 lights the highest-numbered LED.
  generate
    for (genvar gi = 0; gi < C_LEDS; gi++) begin : g_test
      assign test_led[3*gi +: 3] = (step_d == STEP_W'(C_LEDS - 1 - gi)) ? 3'b111 : 3'b000;
    end
  endgenerate

  // Outputs are decided from the next state so they line up with the state.
  always_comb begin
    if (state_d == ST_TEST) begin
      led_d  = test_led;
      busy_d = 1'b1;
    end else begin
      led_d  = normal_led;
      busy_d = 1'b0;
    end
  end
`else
  logic unused_in_test;
  assign unused_in_test = bus.inTest;

  always_comb begin
    led_d  = normal_led;
    busy_d = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sel_q       <= '0;
      bright_q    <= '0;
      cnt_q       <= '0;
      presc_q     <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      busy_q      <= 1'b0;
`ifdef LIGHT_PWM_LAMPTEST_EN
      state_q     <= ST_NORMAL;
      test_prev_q <= 1'b0;
      step_q      <= '0;
      step_tmr_q  <= '0;
`endif
    end else begin
      sel_q       <= sel_d;
      bright_q    <= bright_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
`ifdef LIGHT_PWM_LAMPTEST_EN
      state_q     <= state_d;
      test_prev_q <= test_prev_d;
      step_q      <= step_d;
      step_tmr_q  <= step_tmr_d;
`endif
    end
  end

  assign bus.outLED      = led_q;
  assign bus.outTestBusy = busy_q;

endmodule

// File: tb/tb_light_pwm.sv
// -----------------------------------------------------------------------------
// tb_light_pwm -- self-checking bench for light_pwm.
// Configuration: C_LEDS=4, C_PWM_BITS=3, C_CLK_FRQ=1000, C_BLINK_MS=4
// (blink half-period / lamp-test step 4 cycles, PWM period 7 cycles).
// A cycle-level model derives every output from elapsed time and the input
// history; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_light_pwm;
  localparam int NL = 4;
  localparam int PB = 3;
  localparam int T  = 4;
  localparam int P  = 7;
`ifdef LIGHT_PWM_LAMPTEST_EN
  localparam bit LAMP = 1'b1;
`else
  localparam bit LAMP = 1'b0;
`endif
  localparam logic [11:0] COLORS = {3'b100, 3'b010, 3'b110, 3'b111};
  localparam logic [15:0] MASKS  = {4'b1000, 4'b0100, 4'b0010, 4'b1001};

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  light_pwm_if #(.C_LEDS(NL), .C_PWM_BITS(PB)) bus ();

  light_pwm #(
    .C_LEDS(NL), .C_PWM_BITS(PB), .C_CLK_FRQ(1000), .C_BLINK_MS(4)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Model: time since reset, brightness in force for the current period,
  // previous selection, length of the current blink run, lamp-test progress.
  // ---------------------------------------------------------------------------
  int m_t, m_bright, m_sel, m_run, m_el;
  bit m_in_test, m_prev_test;

  function automatic logic [11:0] normal_out(input int sel, input bit on);
    logic [11:0] colors = COLORS;
    logic [15:0] masks  = MASKS;
    logic [11:0] r      = '0;
    for (int k = 0; k < NL; k++)
      if (on && masks[(3 - sel) * NL + k]) r[3*k +: 3] = colors[3*k +: 3];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [11:0] e_led;
    logic        e_busy;
    if (!rstb) begin
      m_t = 0; m_bright = 0; m_sel = 0; m_run = 0; m_el = 0;
      m_in_test = 0; m_prev_test = 0;
      e_led = '0; e_busy = 1'b0;
    end else begin
      if (LAMP && !m_in_test && bus.inTest && !m_prev_test) begin
        m_in_test = 1; m_el = 0;
      end
      if (m_in_test && m_el < NL * T) begin
        e_led = '0;
        e_led[3*(NL - 1 - m_el / T) +: 3] = 3'b111;
        e_busy = 1'b1;
        m_el++;
      end else begin
        m_in_test = 0;
        e_led  = normal_out(m_sel, ((m_t % P) < m_bright) &&
                                   (!bus.inBlink || ((m_run / T) % 2 == 0)));
        e_busy = 1'b0;
      end
      if (m_t % P == P - 1) m_bright = int'(bus.inBright);
      m_t++;
      m_sel       = int'(bus.inSel);
      m_run       = bus.inBlink ? m_run + 1 : 0;
      m_prev_test = bus.inTest;
    end
    #1;
    chk("model_led", {20'd0, bus.outLED}, {20'd0, e_led});
    chk("model_busy", {31'd0, bus.outTestBusy}, {31'd0, e_busy});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int lit;
    int busy_n;
    logic [15:0]  blink_pat;
    logic [11:0]  lamp_tbl [4];

    bus.inSel = 2'd0; bus.inBright = 3'd0; bus.inBlink = 1'b0; bus.inTest = 1'b0;
    rstb = 1'b0;
    step(3);
    chk("reset_led", {20'd0, bus.outLED}, 32'd0);
    chk("reset_busy", {31'd0, bus.outTestBusy}, 32'd0);
    $display("scenario reset: outLED=%0h busy=%0b", bus.outLED, bus.outTestBusy);

    // Release with full brightness requested: dark until the first wrap.
    bus.inSel = 2'd3; bus.inBright = 3'd7; rstb = 1'b1;
    step(4);
    chk("dark_before_wrap", {20'd0, bus.outLED}, 32'd0);
    step(5);
    chk("lit_after_wrap", {20'd0, bus.outLED}, {20'd0, 12'b100000000111});
    $display("scenario first_wrap: outLED=%b", bus.outLED);

    // Selection latency: two cycles from input change to output.
    bus.inSel = 2'd0;
    step(1); chk("sel_3to0_lat1", {20'd0, bus.outLED}, {20'd0, 12'b100000000111});
    step(1); chk("sel_3to0_lat2", {20'd0, bus.outLED}, {20'd0, 12'b100000000000});
    bus.inSel = 2'd3;
    step(1); chk("sel_0to3_lat1", {20'd0, bus.outLED}, {20'd0, 12'b100000000000});
    step(1); chk("sel_0to3_lat2", {20'd0, bus.outLED}, {20'd0, 12'b100000000111});
    step(3); chk("sel_steady", {20'd0, bus.outLED}, {20'd0, 12'b100000000111});
    $display("scenario sel_latency: outLED=%b", bus.outLED);

    // PWM duty 3/7.
    bus.inSel = 2'd0; bus.inBright = 3'd3;
    step(14);
    lit = 0;
    for (int i = 0; i < P; i++) begin
      step(1);
      if (bus.outLED == 12'b100000000000) lit++;
    end
    chk("pwm_duty3", lit, 3);
    $display("scenario pwm3: lit %0d of 7", lit);

    // Mid-period brightness change: align so the next edge is counter 1.
    for (int i = 0; i < 10 && (m_t % P) != 1; i++) step(1);
    if ((m_t % P) != 1) chk("align_timeout", 0, 1);
    bus.inBright = 3'd7;
    lit = 0;
    for (int i = 0; i < P - 1; i++) begin
      step(1);
      if (bus.outLED == 12'b100000000000) lit++;
    end
    chk("mid_period_hold", lit, 2);
    lit = 0;
    for (int i = 0; i < P; i++) begin
      step(1);
      if (bus.outLED == 12'b100000000000) lit++;
    end
    chk("new_bright_after_wrap", lit, 7);
    $display("scenario mid_period: new period lit %0d of 7", lit);

    bus.inBright = 3'd0;
    step(14);
    lit = 0;
    for (int i = 0; i < P; i++) begin
      step(1);
      if (bus.outLED != 12'd0) lit++;
    end
    chk("pwm_off", lit, 0);
    $display("scenario pwm0: lit %0d of 7", lit);

    // Blink: 4 on, 4 off, starting with a full on half-period.
    bus.inBright = 3'd7;
    step(14);
    bus.inBlink = 1'b1;
    blink_pat = 16'b1111000011110000;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("blink_pattern", {31'd0, bus.outLED != 12'd0}, {31'd0, blink_pat[15 - i]});
    end
    bus.inBlink = 1'b0;
    step(1); chk("blink_off_on1", {20'd0, bus.outLED}, {20'd0, 12'b100000000000});
    step(4); chk("blink_off_on2", {20'd0, bus.outLED}, {20'd0, 12'b100000000000});
    $display("scenario blink: done, outLED=%b", bus.outLED);

`ifdef LIGHT_PWM_LAMPTEST_EN
    lamp_tbl[0] = 12'b111000000000;
    lamp_tbl[1] = 12'b000111000000;
    lamp_tbl[2] = 12'b000000111000;
    lamp_tbl[3] = 12'b000000000111;
    bus.inTest = 1'b1;
    busy_n = 0;
    for (int i = 0; i <= 16; i++) begin
      step(1);
      if (i == 0) bus.inTest = 1'b0;
      if (i == 5) bus.inTest = 1'b1;
      if (i == 6) bus.inTest = 1'b0;
      chk("lamp_led", {20'd0, bus.outLED},
          {20'd0, (i < 16) ? lamp_tbl[i / 4] : 12'b100000000000});
      busy_n += int'(bus.outTestBusy);
    end
    chk("lamp_busy_cycles", busy_n, 16);
    $display("scenario lamp_test: busy %0d cycles", busy_n);

    // Reset during step 2 of a lamp test.
    step(2);
    bus.inTest = 1'b1;
    step(1);
    bus.inTest = 1'b0;
    step(9);
    chk("lamp_step2", {20'd0, bus.outLED}, {20'd0, 12'b000000111000});
    rstb = 1'b0;
    #1;
    chk("abort_led", {20'd0, bus.outLED}, 32'd0);
    chk("abort_busy", {31'd0, bus.outTestBusy}, 32'd0);
    step(2);
    rstb = 1'b1;
    step(4);
    chk("abort_dark", {20'd0, bus.outLED}, 32'd0);
    chk("abort_normal", {31'd0, bus.outTestBusy}, 32'd0);
    step(5);
    chk("abort_lit", {20'd0, bus.outLED}, {20'd0, 12'b100000000000});
    $display("scenario lamp_abort: outLED=%b busy=%0b", bus.outLED, bus.outTestBusy);
`else
    lamp_tbl[0] = 12'd0; lamp_tbl[1] = 12'd0; lamp_tbl[2] = 12'd0; lamp_tbl[3] = 12'd0;
    bus.inSel = 2'd3;
    step(3);
    bus.inTest = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 0) bus.inTest = 1'b0;
      chk("notest_led", {20'd0, bus.outLED}, {20'd0, 12'b100000000111});
      busy_n += int'(bus.outTestBusy);
    end
    chk("notest_busy", busy_n, 0);
    $display("scenario test_disabled: busy %0d cycles, outLED=%b", busy_n, bus.outLED);
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/light_pwm.md
LIGHT_PWM -- requirements
Module: light_pwm

Interface
REQ-001 SHALL have parameter C_LEDS, default 4, giving the number of RGB LEDs (3 bits each; LED k occupies outLED[3k+2:3k]).
REQ-002 SHALL have parameter C_PWM_BITS, default 8, giving the brightness resolution.
REQ-003 SHALL have parameter C_CLK_FRQ, default 100000000, giving the clock frequency in Hz.
REQ-004 SHALL have parameter C_BLINK_MS, default 500, giving the blink half-period and lamp-test step time in ms.
REQ-005 SHALL have parameter C_COLORS [3*C_LEDS-1:0], default {3'b100,3'b010,3'b110,3'b111}, giving the per-LED colour (red, green, yellow, walk-white; MSB triplet = LED C_LEDS-1).
REQ-006 SHALL have parameter C_MASKS [4*C_LEDS-1:0], default {4'b1000,4'b0100,4'b0010,4'b1001}, giving the LED-enable mask per selection code (MSB nibble = code 0).
REQ-007 clk  input  1  master clock.
REQ-008 rstb  input  1  reset, asynchronous, active-low.
REQ-009 inSel  input  2  light selection code.
REQ-010 inBright  input  C_PWM_BITS  brightness (0 = off, all-ones = 100 %).
REQ-011 inBlink  input  1  blink enable.
REQ-012 inTest  input  1  lamp-test request (rising edge).
REQ-013 outLED  output  3*C_LEDS  registered RGB drive.
REQ-014 outTestBusy  output  1  high while the lamp test runs.

Function
REQ-015 SHALL register inSel each cycle; outLED SHALL reflect a new inSel exactly 2 cycles after the input change (sel register + output register).
REQ-016 SHALL run a free-running PWM counter over 0..2^C_PWM_BITS-2 (period 2^C_PWM_BITS-1 cycles), wrapping to 0.
REQ-017 SHALL sample inBright into rBright only on the cycle the PWM counter wraps to 0; mid-period changes SHALL NOT alter the current period.
REQ-018 PWM gate SHALL be high when counter < rBright; rBright=0 -> always off; rBright=all-ones -> always on.
REQ-019 SHALL run a blink prescaler of T = C_CLK_FRQ/1000*C_BLINK_MS cycles (T >= 2 required); blink phase SHALL toggle when the prescaler reaches T-1 and the prescaler SHALL then wrap to 0.
REQ-020 While inBlink=0, prescaler SHALL be held at 0 and phase held on; blinking SHALL therefore start with a full on half-period.
REQ-021 NORMAL state: outLED triplet k SHALL equal C_COLORS triplet k AND mask bit k of C_MASKS[rSel] AND PWM gate AND (phase or not inBlink).
REQ-022 FSM states: NORMAL, TEST; TEST exists only under REQ-030.
REQ-023 NORMAL -> TEST on inTest rising edge (registered edge detect); TEST SHALL light LED C_LEDS-1 down to LED 0 one at a time, each 3'b111 at full brightness, blink ignored, for T cycles each, then return to NORMAL.
REQ-024 inTest edges during TEST SHALL be ignored; inSel/inBright/inBlink SHALL keep being tracked so NORMAL resumes with current values.
REQ-025 outTestBusy SHALL be 1 exactly while in TEST.

Reset
REQ-026 rstb low SHALL asynchronously clear outLED to 0, outTestBusy to 0, PWM counter, prescaler, rSel and rBright to 0, phase to on, state to NORMAL.
REQ-027 Reset asserted mid-TEST SHALL abort the test; after release the block SHALL be in NORMAL.
REQ-028 First post-reset PWM period SHALL use rBright=0 (outputs dark until first wrap).
REQ-029 Reset release SHALL be tolerated on any cycle; no input SHALL be required stable during release.

Configuration
REQ-030 Macro LIGHT_PWM_LAMPTEST_EN defined: TEST state, step counter and inTest edge detector SHALL be present per REQ-023..025.
REQ-031 Macro undefined: inTest SHALL be ignored, outTestBusy SHALL be tied 0, FSM reduces to NORMAL only; all other behaviour unchanged.

Verification (C_LEDS=4, C_PWM_BITS=3, C_CLK_FRQ=1000, C_BLINK_MS=4 -> T=4, PWM period 7)
REQ-032 inSel 00->11, inBright=7, inBlink=0 -> 2 cycles later outLED=12'b100000000111, steady.
REQ-033 inSel=00, inBright=3 -> outLED=12'b100000000000 for 3 of every 7 cycles, 0 otherwise; inBright changed mid-period takes effect only after wrap.
REQ-034 inBright=7, inBlink 0->1 -> LED pattern on 4 cycles, off 4 cycles, repeating; inBlink->0 -> steady on.
REQ-035 (macro on) inTest pulse -> outTestBusy=1 for 16 cycles; outLED = 111 on LED3, LED2, LED1, LED0 for 4 cycles each, then NORMAL output.
REQ-036 rstb low during TEST step 2 -> outLED=0, outTestBusy=0 immediately; after release NORMAL, dark until first PWM wrap.
REQ-037 (macro off) inTest pulse -> outTestBusy stays 0, outLED unaffected.
